// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared definitions for the uBlock key-schedule S-box path.
//   state_e       sequencer states (IDLE / ISSUE / DRAIN)
//   WORD_W        width of one key word per share
//   N_WORDS_DEF   default number of words substituted per request
//   SBOX_LAT_DEF  default pipeline depth of the shared S-box array
package key_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned N_WORDS_DEF  = 4;
  localparam int unsigned SBOX_LAT_DEF = 2;

endpackage

// File: rtl/sbox_valid_pipe.sv
// sbox_valid_pipe: SBOX_LAT-deep shift register of valid tags that mirrors the
// S-box array's pipeline, so valid_o rises exactly when the array output
// belonging to a tagged input is present.
//   clk_i    clock, rising edge
//   clr_i    synchronous clear of every stage
//   valid_i  tag pushed this cycle
//   valid_o  tag leaving the pipe this cycle
module sbox_valid_pipe
  import key_sched_pkg::*;
#(
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [SBOX_LAT-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= valid_i;
      for (int unsigned i = 1; i < SBOX_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[SBOX_LAT-1];

endmodule

// File: rtl/key_sbox_sequencer.sv
// key_sbox_sequencer: streams a two-share key state word by word through the
// external threshold S-box array and collects the substituted words.
//   clk, rst              clock and synchronous active-high reset
//   start                 request, sampled only while idle
//   key_in0 / key_in1     key shares, word i at [32*i +: 32]
//   busy                  request in flight (ISSUE or DRAIN)
//   done                  one-cycle pulse after the final capture
//   key_out0 / key_out1   substituted shares, same layout as key_in*
//   sbox_in0 / sbox_in1   array inputs, forced to zero outside ISSUE
//   sbox_out0 / sbox_out1 array outputs, SBOX_LAT cycles after input
module key_sbox_sequencer
  import key_sched_pkg::*;
#(
  parameter int unsigned N_WORDS  = N_WORDS_DEF,
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_W*N_WORDS-1:0] key_in0,
  input  logic [WORD_W*N_WORDS-1:0] key_in1,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_W*N_WORDS-1:0] key_out0,
  output logic [WORD_W*N_WORDS-1:0] key_out1,
  output logic [WORD_W-1:0]         sbox_in0,
  output logic [WORD_W-1:0]         sbox_in1,
  input  logic [WORD_W-1:0]         sbox_out0,
  input  logic [WORD_W-1:0]         sbox_out1
);

  localparam int unsigned CNT_W = $clog2(N_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic             done_q, done_d;
  logic             accept, issue, tag_out;

  logic [WORD_W-1:0] sh0_q [N_WORDS];
  logic [WORD_W-1:0] sh1_q [N_WORDS];
  logic [WORD_W-1:0] ko0_q [N_WORDS];
  logic [WORD_W-1:0] ko1_q [N_WORDS];

  // Reset also flushes the tags, so words still inside the (unreset) array
  // after an aborted request are never captured.
  sbox_valid_pipe #(
    .SBOX_LAT(SBOX_LAT)
  ) u_valid_pipe (
    .clk_i  (clk),
    .clr_i  (rst),
    .valid_i(issue),
    .valid_o(tag_out)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    issue       = 1'b0;

    if (tag_out) begin
      cap_cnt_d = cap_cnt_q + CNT_W'(1);
      if (cap_cnt_q == LAST) done_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept      = 1'b1;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue       = 1'b1;
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (issue_cnt_q == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tag_out && (cap_cnt_q == LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        sh0_q[i] <= '0;
        sh1_q[i] <= '0;
        ko0_q[i] <= '0;
        ko1_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < N_WORDS; i++) begin
          sh0_q[i] <= key_in0[WORD_W*i +: WORD_W];
          sh1_q[i] <= key_in1[WORD_W*i +: WORD_W];
        end
      end
      if (tag_out) begin
        for (int unsigned i = 0; i < N_WORDS; i++) begin
          if (cap_cnt_q == CNT_W'(i)) begin
            ko0_q[i] <= sbox_out0;
            ko1_q[i] <= sbox_out1;
          end
        end
      end
    end
  end

  // Array inputs are held at zero except while issuing, so the two shares of
  // an unrelated word never meet inside the array.
  always_comb begin
    sbox_in0 = '0;
    sbox_in1 = '0;
    if (issue) begin
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        if (issue_cnt_q == CNT_W'(i)) begin
          sbox_in0 = sh0_q[i];
          sbox_in1 = sh1_q[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_out
    assign key_out0[WORD_W*gi +: WORD_W] = ko0_q[gi];
    assign key_out1[WORD_W*gi +: WORD_W] = ko1_q[gi];
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_key_sbox_sequencer.sv
// Bench for key_sbox_sequencer: three instances (4/2, 1/1, 16/4 words/latency),
// each attached to a behavioural two-share S-box array, checked against a
// nibble-wise uBlock S-box reference of the unmasked key.
module tb_key_sbox_sequencer;

  localparam logic [3:0] SBOX [16] = '{4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
                                       4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]   start_v, busy_v, done_v;
  logic [511:0] k0_v [3];
  logic [511:0] k1_v [3];
  logic [511:0] ko0_v [3];
  logic [511:0] ko1_v [3];
  logic [31:0]  si0_v [3];
  logic [31:0]  si1_v [3];

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] sbox32(logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int n = 0; n < 8; n++) y[4*n +: 4] = SBOX[x[4*n +: 4]];
    return y;
  endfunction

  // Unmasked result: S applied to every nibble of (share0 ^ share1).
  function automatic logic [511:0] ref_sub(logic [511:0] a, logic [511:0] b, int nw);
    logic [511:0] r;
    r = '0;
    for (int w = 0; w < nw; w++) r[32*w +: 32] = sbox32(a[32*w +: 32] ^ b[32*w +: 32]);
    return r;
  endfunction

  function automatic logic [511:0] rand_key(int nw);
    logic [511:0] k;
    k = '0;
    for (int w = 0; w < nw; w++) k[32*w +: 32] = $urandom;
    return k;
  endfunction

  task automatic check_eq(string tag, logic [511:0] got, logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned NW = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    localparam int unsigned LT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [32*NW-1:0] k0, k1, ko0, ko1;
    logic [31:0]      si0, si1, so0, so1;
    logic [31:0]      pa0 [LT];
    logic [31:0]      pa1 [LT];
    logic             b, d;

    assign k0 = k0_v[g][32*NW-1:0];
    assign k1 = k1_v[g][32*NW-1:0];

    key_sbox_sequencer #(
      .N_WORDS (NW),
      .SBOX_LAT(LT)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .key_in0  (k0),
      .key_in1  (k1),
      .busy     (b),
      .done     (d),
      .key_out0 (ko0),
      .key_out1 (ko1),
      .sbox_in0 (si0),
      .sbox_in1 (si1),
      .sbox_out0(so0),
      .sbox_out1(so1)
    );

    // Behavioural masked array: remasks with fresh randomness, not reset.
    always @(posedge clk) begin : array_model
      logic [31:0] r;
      r = $urandom;
      pa0[0] <= sbox32(si0 ^ si1) ^ r;
      pa1[0] <= r;
      for (int i = 1; i < LT; i++) begin
        pa0[i] <= pa0[i-1];
        pa1[i] <= pa1[i-1];
      end
    end
    assign so0 = pa0[LT-1];
    assign so1 = pa1[LT-1];

    assign ko0_v[g]  = 512'(ko0);
    assign ko1_v[g]  = 512'(ko1);
    assign si0_v[g]  = si0;
    assign si1_v[g]  = si1;
    assign busy_v[g] = b;
    assign done_v[g] = d;
  end

  // One request on instance id with start in cycle 0; checks busy/done every
  // cycle, array-input gating on instance 0, and the result at done.
  task automatic run_req(int id, int nw, int lat, logic [511:0] a, logic [511:0] b, string nm);
    logic [511:0] exp;
    logic [31:0]  e0, e1;
    exp = ref_sub(a, b, nw);
    for (int c = 0; c <= nw + lat + 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        k0_v[id] = a;
        k1_v[id] = b;
        start_v[id] = 1'b1;
      end else begin
        start_v[id] = 1'b0;
      end
      @(negedge clk);
      check_eq({nm, "/busy"}, 512'(busy_v[id]), 512'(c >= 1 && c <= nw + lat));
      check_eq({nm, "/done"}, 512'(done_v[id]), 512'(c == nw + lat + 1));
      if (id == 0) begin
        e0 = '0;
        e1 = '0;
        if (c >= 1 && c <= nw) begin
          e0 = a[32*(c-1) +: 32];
          e1 = b[32*(c-1) +: 32];
        end
        check_eq({nm, "/sbox_in0"}, 512'(si0_v[0]), 512'(e0));
        check_eq({nm, "/sbox_in1"}, 512'(si1_v[0]), 512'(e1));
      end
      if (c == nw + lat + 1) check_eq({nm, "/result"}, ko0_v[id] ^ ko1_v[id], exp);
    end
  endtask

  initial begin : stim
    logic [511:0] a1, b1, a2, b2;
    rst = 1'b1;
    start_v = '0;
    for (int i = 0; i < 3; i++) begin
      k0_v[i] = '0;
      k1_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("reset/busy", 512'(busy_v[i]), '0);
      check_eq("reset/done", 512'(done_v[i]), '0);
      check_eq("reset/key_out0", ko0_v[i], '0);
      check_eq("reset/key_out1", ko1_v[i], '0);
      check_eq("reset/sbox_in0", 512'(si0_v[i]), '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request with the fixed share-0 pattern.
    a1 = '0;
    a1[127:0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    run_req(0, 4, 2, a1, rand_key(4), "single");

    // start held high through cycles 0..10, key_in changed at cycle 2.
    a1 = rand_key(4); b1 = rand_key(4);
    a2 = rand_key(4); b2 = rand_key(4);
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      start_v[0] = (c <= 10);
      if (c == 0) begin k0_v[0] = a1; k1_v[0] = b1; end
      if (c == 2) begin k0_v[0] = a2; k1_v[0] = b2; end
      @(negedge clk);
      check_eq("held/busy", 512'(busy_v[0]), 512'((c >= 1 && c <= 6) || (c >= 8 && c <= 13)));
      check_eq("held/done", 512'(done_v[0]), 512'(c == 7 || c == 14));
      if (c == 7)  check_eq("held/result1", ko0_v[0] ^ ko1_v[0], ref_sub(a1, b1, 4));
      if (c == 14) check_eq("held/result2", ko0_v[0] ^ ko1_v[0], ref_sub(a2, b2, 4));
    end
    @(posedge clk); #1;
    start_v[0] = 1'b0;

    // Reset asserted in cycle 4 of a request.
    a1 = rand_key(4); b1 = rand_key(4);
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      start_v[0] = (c == 0);
      if (c == 0) begin k0_v[0] = a1; k1_v[0] = b1; end
      rst = (c == 4);
      @(negedge clk);
      if (c == 5) begin
        check_eq("rstmid/busy", 512'(busy_v[0]), '0);
        check_eq("rstmid/key_out0", ko0_v[0], '0);
        check_eq("rstmid/key_out1", ko1_v[0], '0);
        check_eq("rstmid/sbox_in0", 512'(si0_v[0]), '0);
      end
      check_eq("rstmid/no_done", 512'(done_v[0]), '0);
    end
    run_req(0, 4, 2, rand_key(4), rand_key(4), "after_rst");

    // Randomized back-to-back style requests on the default configuration.
    for (int t = 0; t < 6; t++) run_req(0, 4, 2, rand_key(4), rand_key(4), "rand");

    // Boundary configurations.
    for (int t = 0; t < 2; t++) begin
      run_req(1, 1, 1, rand_key(1), rand_key(1), "nw1_lat1");
      run_req(2, 16, 4, rand_key(16), rand_key(16), "nw16_lat4");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
